// File: rtl/sat_accumulator.sv
// Accumulates N_TERMS signed terms into a symmetric-saturating sum and holds the result for a
// valid/ready handshake. Define SAT_ACC_STICKY_FLAG_EN to enable the sticky saturation flag.
module sat_accumulator #(
  parameter int unsigned WIDTH_SUM = 4,
  parameter int unsigned N_TERMS   = 4
) (
  input  logic                 clk_80,
  input  logic                 reset_80,
  input  logic                 in_valid_80,
  input  logic [WIDTH_SUM-1:0] in_data_80,
  output logic                 in_ready_80,
  output logic                 out_valid_80,
  output logic [WIDTH_SUM-1:0] out_sum_80,
  input  logic                 out_ready_80,
  output logic                 sat_flag_80
);

  localparam int unsigned CNT_W = $clog2(N_TERMS + 1);

  localparam logic [WIDTH_SUM-1:0] ILLEGAL_VAL = {1'b1, {(WIDTH_SUM-1){1'b0}}};
  localparam logic [WIDTH_SUM-1:0] MAX_VAL     = {1'b0, {(WIDTH_SUM-1){1'b1}}};
  localparam logic [WIDTH_SUM-1:0] MIN_VAL     = {1'b1, {(WIDTH_SUM-2){1'b0}}, 1'b1};
  localparam logic signed [WIDTH_SUM:0] SUM_MAX = {2'b00, {(WIDTH_SUM-1){1'b1}}};
  localparam logic signed [WIDTH_SUM:0] SUM_MIN = {2'b11, {(WIDTH_SUM-2){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t               state_q, state_d;
  logic [WIDTH_SUM-1:0] acc_q, acc_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;

  logic [WIDTH_SUM-1:0]      term_c;
  logic signed [WIDTH_SUM:0] sum_c;
  logic                      sat_hi_c, sat_lo_c;
  logic [WIDTH_SUM-1:0]      clamped_c;

  // Illegal most-negative term is folded onto the symmetric minimum before the add.
  always_comb begin
    term_c    = (in_data_80 == ILLEGAL_VAL) ? MIN_VAL : in_data_80;
    sum_c     = $signed({acc_q[WIDTH_SUM-1], acc_q}) + $signed({term_c[WIDTH_SUM-1], term_c});
    sat_hi_c  = (sum_c > SUM_MAX);
    sat_lo_c  = (sum_c < SUM_MIN);
    clamped_c = sat_hi_c ? MAX_VAL : (sat_lo_c ? MIN_VAL : sum_c[WIDTH_SUM-1:0]);
  end

`ifdef SAT_ACC_STICKY_FLAG_EN
  logic sat_q, sat_d;
`endif

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
`ifdef SAT_ACC_STICKY_FLAG_EN
    sat_d   = sat_q;
`endif
    case (state_q)
      IDLE, ACCUM: begin
        if (in_valid_80) begin
          acc_d = clamped_c;
          cnt_d = cnt_q + CNT_W'(1);
`ifdef SAT_ACC_STICKY_FLAG_EN
          sat_d = sat_q | sat_hi_c | sat_lo_c;
`endif
          state_d = (cnt_q == CNT_W'(N_TERMS - 1)) ? DONE : ACCUM;
        end
      end
      DONE: begin
        if (out_ready_80) begin
          state_d = IDLE;
          acc_d   = '0;
          cnt_d   = '0;
`ifdef SAT_ACC_STICKY_FLAG_EN
          sat_d   = 1'b0;
`endif
        end
      end
      default: begin
        state_d = IDLE;
        acc_d   = '0;
        cnt_d   = '0;
`ifdef SAT_ACC_STICKY_FLAG_EN
        sat_d   = 1'b0;
`endif
      end
    endcase
  end

  always_ff @(posedge clk_80) begin
    if (reset_80) begin
      state_q <= IDLE;
      acc_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
    end
  end

`ifdef SAT_ACC_STICKY_FLAG_EN
  always_ff @(posedge clk_80) begin
    if (reset_80) sat_q <= 1'b0;
    else          sat_q <= sat_d;
  end
  assign sat_flag_80 = sat_q;
`else
  assign sat_flag_80 = 1'b0;
`endif

  assign in_ready_80  = (state_q != DONE) && !reset_80;
  assign out_valid_80 = (state_q == DONE);
  assign out_sum_80   = acc_q;

endmodule

// File: tb/tb_sat_accumulator.sv
// Directed bench for sat_accumulator (WIDTH_SUM=4, N_TERMS=4); the saturation-flag
// expectation follows whether SAT_ACC_STICKY_FLAG_EN is defined for the build.
module tb_sat_accumulator;

  localparam int unsigned W = 4;
`ifdef SAT_ACC_STICKY_FLAG_EN
  localparam bit STICKY = 1'b1;
`else
  localparam bit STICKY = 1'b0;
`endif

  logic         clk_80 = 1'b0;
  logic         reset_80;
  logic         in_valid_80;
  logic [W-1:0] in_data_80;
  logic         in_ready_80;
  logic         out_valid_80;
  logic [W-1:0] out_sum_80;
  logic         out_ready_80;
  logic         sat_flag_80;

  int n_cmp = 0;
  int n_err = 0;

  sat_accumulator #(.WIDTH_SUM(W), .N_TERMS(4)) dut (
    .clk_80       (clk_80),
    .reset_80     (reset_80),
    .in_valid_80  (in_valid_80),
    .in_data_80   (in_data_80),
    .in_ready_80  (in_ready_80),
    .out_valid_80 (out_valid_80),
    .out_sum_80   (out_sum_80),
    .out_ready_80 (out_ready_80),
    .sat_flag_80  (sat_flag_80)
  );

  always #5 clk_80 = ~clk_80;

  // Presents one term for exactly one edge; returns 1 time unit after that edge.
  task automatic send(input logic [W-1:0] d);
    in_valid_80 = 1'b1;
    in_data_80  = d;
    @(posedge clk_80); #1;
    in_valid_80 = 1'b0;
  endtask

  task automatic idle_cycle();
    @(posedge clk_80); #1;
  endtask

  task automatic test_reset();
    reset_80 = 1'b1;
    idle_cycle();
    idle_cycle();
    n_cmp++; if (out_valid_80 !== 1'b0) begin n_err++; $display("FAIL reset_out_valid got %b want 0", out_valid_80); end
    n_cmp++; if (out_sum_80 !== 4'b0000) begin n_err++; $display("FAIL reset_out_sum got %b want 0000", out_sum_80); end
    n_cmp++; if (sat_flag_80 !== 1'b0) begin n_err++; $display("FAIL reset_sat_flag got %b want 0", sat_flag_80); end
    n_cmp++; if (in_ready_80 !== 1'b0) begin n_err++; $display("FAIL reset_in_ready got %b want 0", in_ready_80); end
    reset_80 = 1'b0;
    idle_cycle();
    n_cmp++; if (in_ready_80 !== 1'b1) begin n_err++; $display("FAIL reset_release_in_ready got %b want 1", in_ready_80); end
    n_cmp++; if (out_valid_80 !== 1'b0) begin n_err++; $display("FAIL reset_release_out_valid got %b want 0", out_valid_80); end
  endtask

  task automatic test_nominal();
    send(4'd1); send(4'd2); send(4'd3);
    n_cmp++; if (out_valid_80 !== 1'b0) begin n_err++; $display("FAIL nominal_early_valid got %b want 0", out_valid_80); end
    send(4'b1111);
    n_cmp++; if (out_valid_80 !== 1'b1) begin n_err++; $display("FAIL nominal_out_valid got %b want 1", out_valid_80); end
    n_cmp++; if (out_sum_80 !== 4'b0101) begin n_err++; $display("FAIL nominal_sum got %b want 0101", out_sum_80); end
    n_cmp++; if (sat_flag_80 !== 1'b0) begin n_err++; $display("FAIL nominal_sat got %b want 0", sat_flag_80); end
    n_cmp++; if (in_ready_80 !== 1'b0) begin n_err++; $display("FAIL nominal_done_ready got %b want 0", in_ready_80); end
    idle_cycle();
    n_cmp++; if (in_ready_80 !== 1'b1) begin n_err++; $display("FAIL nominal_next_ready got %b want 1", in_ready_80); end
    n_cmp++; if (out_valid_80 !== 1'b0) begin n_err++; $display("FAIL nominal_next_valid got %b want 0", out_valid_80); end
    n_cmp++; if (out_sum_80 !== 4'b0000) begin n_err++; $display("FAIL nominal_cleared_acc got %b want 0000", out_sum_80); end
  endtask

  task automatic test_pos_saturation();
    send(4'd7); send(4'd7);
    n_cmp++; if (out_sum_80 !== 4'b0111) begin n_err++; $display("FAIL possat_clamped_acc got %b want 0111", out_sum_80); end
    n_cmp++; if (sat_flag_80 !== STICKY) begin n_err++; $display("FAIL possat_flag_mid got %b want %b", sat_flag_80, STICKY); end
    send(4'b1101); send(4'd1);
    n_cmp++; if (out_valid_80 !== 1'b1) begin n_err++; $display("FAIL possat_valid got %b want 1", out_valid_80); end
    n_cmp++; if (out_sum_80 !== 4'b0101) begin n_err++; $display("FAIL possat_sum got %b want 0101", out_sum_80); end
    n_cmp++; if (sat_flag_80 !== STICKY) begin n_err++; $display("FAIL possat_flag got %b want %b", sat_flag_80, STICKY); end
    idle_cycle();
    n_cmp++; if (sat_flag_80 !== 1'b0) begin n_err++; $display("FAIL possat_flag_clear got %b want 0", sat_flag_80); end
  endtask

  task automatic test_illegal_input();
    send(4'b1000); send(4'b0000); send(4'b0000); send(4'b0000);
    n_cmp++; if (out_sum_80 !== 4'b1001) begin n_err++; $display("FAIL illegal_sum got %b want 1001", out_sum_80); end
    n_cmp++; if (sat_flag_80 !== 1'b0) begin n_err++; $display("FAIL illegal_flag got %b want 0", sat_flag_80); end
    idle_cycle();
    send(4'b1001); send(4'b1001); send(4'b0000); send(4'b0000);
    n_cmp++; if (out_sum_80 !== 4'b1001) begin n_err++; $display("FAIL negsat_sum got %b want 1001", out_sum_80); end
    n_cmp++; if (sat_flag_80 !== STICKY) begin n_err++; $display("FAIL negsat_flag got %b want %b", sat_flag_80, STICKY); end
    idle_cycle();
  endtask

  task automatic test_backpressure();
    out_ready_80 = 1'b0;
    send(4'd1); send(4'd1); send(4'd1); send(4'd0);
    in_valid_80 = 1'b1;
    in_data_80  = 4'b0011;
    for (int i = 0; i < 3; i++) begin
      n_cmp++; if (out_valid_80 !== 1'b1) begin n_err++; $display("FAIL bp_valid[%0d] got %b want 1", i, out_valid_80); end
      n_cmp++; if (out_sum_80 !== 4'b0011) begin n_err++; $display("FAIL bp_sum[%0d] got %b want 0011", i, out_sum_80); end
      n_cmp++; if (in_ready_80 !== 1'b0) begin n_err++; $display("FAIL bp_in_ready[%0d] got %b want 0", i, in_ready_80); end
      idle_cycle();
    end
    in_valid_80  = 1'b0;
    out_ready_80 = 1'b1;
    idle_cycle();
    n_cmp++; if (out_valid_80 !== 1'b0) begin n_err++; $display("FAIL bp_release_valid got %b want 0", out_valid_80); end
    n_cmp++; if (in_ready_80 !== 1'b1) begin n_err++; $display("FAIL bp_release_ready got %b want 1", in_ready_80); end
    n_cmp++; if (out_sum_80 !== 4'b0000) begin n_err++; $display("FAIL bp_release_acc got %b want 0000", out_sum_80); end
  endtask

  task automatic test_idle_gap();
    send(4'd2);
    idle_cycle(); idle_cycle();
    send(4'd2); send(4'd2);
    n_cmp++; if (out_valid_80 !== 1'b0) begin n_err++; $display("FAIL gap_early_valid got %b want 0", out_valid_80); end
    send(4'b1111);
    n_cmp++; if (out_valid_80 !== 1'b1) begin n_err++; $display("FAIL gap_valid got %b want 1", out_valid_80); end
    n_cmp++; if (out_sum_80 !== 4'b0101) begin n_err++; $display("FAIL gap_sum got %b want 0101", out_sum_80); end
    idle_cycle();
  endtask

  task automatic test_reset_mid();
    send(4'd3); send(4'd3);
    reset_80 = 1'b1;
    #1;
    n_cmp++; if (in_ready_80 !== 1'b0) begin n_err++; $display("FAIL midrst_in_ready got %b want 0", in_ready_80); end
    idle_cycle();
    n_cmp++; if (out_sum_80 !== 4'b0000) begin n_err++; $display("FAIL midrst_acc got %b want 0000", out_sum_80); end
    reset_80 = 1'b0;
    send(4'd1); send(4'd1); send(4'd1);
    n_cmp++; if (out_valid_80 !== 1'b0) begin n_err++; $display("FAIL midrst_early_valid got %b want 0", out_valid_80); end
    send(4'd1);
    n_cmp++; if (out_valid_80 !== 1'b1) begin n_err++; $display("FAIL midrst_valid got %b want 1", out_valid_80); end
    n_cmp++; if (out_sum_80 !== 4'b0100) begin n_err++; $display("FAIL midrst_sum got %b want 0100", out_sum_80); end
    out_ready_80 = 1'b0;
    idle_cycle();
    reset_80 = 1'b1;
    idle_cycle();
    n_cmp++; if (out_valid_80 !== 1'b0) begin n_err++; $display("FAIL donerst_valid got %b want 0", out_valid_80); end
    n_cmp++; if (out_sum_80 !== 4'b0000) begin n_err++; $display("FAIL donerst_sum got %b want 0000", out_sum_80); end
    reset_80     = 1'b0;
    out_ready_80 = 1'b1;
    idle_cycle();
  endtask

  initial begin
    reset_80     = 1'b1;
    in_valid_80  = 1'b0;
    in_data_80   = '0;
    out_ready_80 = 1'b1;
    #1;
    test_reset();
    test_nominal();
    test_pos_saturation();
    test_illegal_input();
    test_backpressure();
    test_idle_gap();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
